// File: rtl/hwpe_stream_fifo_wm.sv
// hwpe_stream_fifo_wm: circular-buffer stream FIFO with byte strobes,
// occupancy count, almost-full/almost-empty watermarks and optional fall-through.
module hwpe_stream_fifo_wm #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned FALL_THROUGH = 0,
    localparam int unsigned CW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    push_valid_i,
    input  logic [DATA_WIDTH-1:0]   push_data_i,
    input  logic [DATA_WIDTH/8-1:0] push_strb_i,
    output logic                    push_ready_o,
    input  logic                    pop_ready_i,
    output logic                    pop_valid_o,
    output logic [DATA_WIDTH-1:0]   pop_data_o,
    output logic [DATA_WIDTH/8-1:0] pop_strb_o,
    input  logic [CW-1:0]           af_thr_i,
    input  logic [CW-1:0]           ae_thr_i,
    output logic [CW-1:0]           count_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic                    almost_full_o,
    output logic                    almost_empty_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned SW = DATA_WIDTH / 8;
    localparam int unsigned EW = DATA_WIDTH + SW;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic bypass;
    logic push_fire;
    logic pop_fire;
    logic do_write;
    logic do_read;

    // Status flags come straight from the registered occupancy count.
    assign count_o        = count;
    assign empty_o        = (count == '0);
    assign full_o         = (count == CW'(FIFO_DEPTH));
    assign almost_full_o  = (count >= af_thr_i);
    assign almost_empty_o = (count <= ae_thr_i);

    // Ready never looks at pop_ready_i; during a flush the FIFO is about to be empty.
    assign push_ready_o = ~full_o | clear_i;

    // Fall-through only applies while nothing is stored.
    assign bypass = (FALL_THROUGH != 0) && empty_o;

    // Downstream view: the head entry, or the incoming word when bypassing.
    always_comb begin
        pop_valid_o              = ~empty_o;
        {pop_strb_o, pop_data_o} = mem[rd_ptr];
        if (bypass) begin
            pop_valid_o = push_valid_i;
            pop_strb_o  = push_strb_i;
            pop_data_o  = push_data_i;
        end
    end

    // A bypassed word consumed in the same cycle never touches storage.
    assign push_fire = push_valid_i & push_ready_o;
    assign pop_fire  = pop_valid_o & pop_ready_i;
    assign do_write  = push_fire & ~clear_i & ~(bypass & pop_fire);
    assign do_read   = pop_fire & ~clear_i & ~bypass;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_write && !do_read) begin
                count <= count + CW'(1);
            end else if (do_read && !do_write) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage array is deliberately left unreset; contents are don't-care when empty.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem[wr_ptr] <= {push_strb_i, push_data_i};
        end
    end

endmodule

// File: tb/tb_hwpe_stream_fifo_wm.sv
// tb_hwpe_stream_fifo_wm: directed stimulus with a scoreboard queue and an
// independent monitor that checks every word leaving the FIFO.
module tb_hwpe_stream_fifo_wm;

    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          push_valid;
    logic [DW-1:0] push_data;
    logic [SW-1:0] push_strb;
    logic          push_ready;
    logic          pop_ready;
    logic          pop_valid;
    logic [DW-1:0] pop_data;
    logic [SW-1:0] pop_strb;
    logic [CW-1:0] af_thr;
    logic [CW-1:0] ae_thr;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          afull;
    logic          aempty;

    logic          ft_clear;
    logic          ft_push_valid;
    logic [DW-1:0] ft_push_data;
    logic [SW-1:0] ft_push_strb;
    logic          ft_push_ready;
    logic          ft_pop_ready;
    logic          ft_pop_valid;
    logic [DW-1:0] ft_pop_data;
    logic [SW-1:0] ft_pop_strb;
    logic [CW-1:0] ft_count;
    logic          ft_empty;
    logic          ft_full;
    logic          ft_afull;
    logic          ft_aempty;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW+SW-1:0] sb[$];

    hwpe_stream_fifo_wm #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .FALL_THROUGH(0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .push_valid_i(push_valid), .push_data_i(push_data), .push_strb_i(push_strb),
        .push_ready_o(push_ready), .pop_ready_i(pop_ready), .pop_valid_o(pop_valid),
        .pop_data_o(pop_data), .pop_strb_o(pop_strb), .af_thr_i(af_thr), .ae_thr_i(ae_thr),
        .count_o(count), .empty_o(empty), .full_o(full),
        .almost_full_o(afull), .almost_empty_o(aempty)
    );

    hwpe_stream_fifo_wm #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .FALL_THROUGH(1)) dut_ft (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(ft_clear),
        .push_valid_i(ft_push_valid), .push_data_i(ft_push_data), .push_strb_i(ft_push_strb),
        .push_ready_o(ft_push_ready), .pop_ready_i(ft_pop_ready), .pop_valid_o(ft_pop_valid),
        .pop_data_o(ft_pop_data), .pop_strb_o(ft_pop_strb), .af_thr_i(4'd8), .ae_thr_i(4'd0),
        .count_o(ft_count), .empty_o(ft_empty), .full_o(ft_full),
        .almost_full_o(ft_afull), .almost_empty_o(ft_aempty)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One cycle of stimulus; expected words are queued at the negedge once acceptance is known.
    task automatic apply_stimulus(input logic pv, input logic [DW-1:0] d,
                                  input logic pr, input logic clr);
        @(posedge clk);
        #1;
        push_valid = pv;
        push_data  = d;
        push_strb  = d[SW-1:0];
        pop_ready  = pr;
        clear      = clr;
        @(negedge clk);
        if (clr) sb.delete();
        else if (pv && push_ready) sb.push_back({d[SW-1:0], d});
    endtask

    task automatic idle();
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic check_status(input string name, input int exp_count,
                                input logic exp_empty, input logic exp_full);
        check_output({name, ".count"}, 64'(count), 64'(exp_count));
        check_output({name, ".empty"}, 64'(empty), 64'(exp_empty));
        check_output({name, ".full"}, 64'(full), 64'(exp_full));
        check_output({name, ".push_ready"}, 64'(push_ready), 64'(!exp_full));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    endtask

    // Monitor: every fired pop must match the oldest outstanding expected word.
    always begin
        logic [DW+SW-1:0] exp;
        @(negedge clk);
        #1;
        if (rst_n && !clear && pop_valid && pop_ready) begin
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL pop_unexpected: got %0h expected no word", {pop_strb, pop_data});
            end else begin
                exp = sb.pop_front();
                check_output("pop_word", 64'({pop_strb, pop_data}), 64'(exp));
            end
        end
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; push_valid = 1'b0; push_data = '0; push_strb = '0;
        pop_ready = 1'b0; af_thr = 4'd8; ae_thr = 4'd0;
        ft_clear = 1'b0; ft_push_valid = 1'b0; ft_push_data = '0; ft_push_strb = '0;
        ft_pop_ready = 1'b0;
        #2;
        check_status("reset", 0, 1'b1, 1'b0);
        check_output("reset.pop_valid", 64'(pop_valid), 64'd0);
        check_output("reset.almost_full", 64'(afull), 64'd0);
        check_output("reset.almost_empty", 64'(aempty), 64'd1);
        #11 rst_n = 1'b1;

        // Fill with 1..8 then drain in order.
        for (int i = 1; i <= 8; i++) apply_stimulus(1'b1, 32'(i), 1'b0, 1'b0);
        idle();
        check_status("fill", 8, 1'b0, 1'b1);
        check_output("fill.almost_full", 64'(afull), 64'd1);
        drain(8);
        idle();
        check_status("drain", 0, 1'b1, 1'b0);

        // Full with push and pop together: only the pop fires.
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 32'h11 + 32'(i), 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h19, 1'b1, 1'b0);
        check_output("fullpop.push_ready", 64'(push_ready), 64'd0);
        idle();
        check_status("fullpop", 7, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h1A, 1'b0, 1'b0);
        idle();
        check_status("fullpop_refill", 8, 1'b0, 1'b1);
        drain(8);
        idle();
        check_status("fullpop_drain", 0, 1'b1, 1'b0);

        // Steady push+pop at occupancy 4 across pointer wrap.
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 32'h21 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 32'h30 + 32'(i), 1'b1, 1'b0);
            check_output("wrap.count", 64'(count), 64'd4);
        end
        drain(4);
        idle();
        check_status("wrap_drain", 0, 1'b1, 1'b0);

        // Watermarks: af=6, ae=2.
        af_thr = 4'd6; ae_thr = 4'd2;
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(1'b1, 32'h40 + 32'(k), 1'b0, 1'b0);
            check_output("wm.almost_full_low", 64'(afull), 64'd0);
        end
        idle();
        check_output("wm.count6", 64'(count), 64'd6);
        check_output("wm.almost_full_high", 64'(afull), 64'd1);
        check_output("wm.almost_empty_at6", 64'(aempty), 64'd0);
        for (int j = 0; j < 4; j++) begin
            apply_stimulus(1'b0, '0, 1'b1, 1'b0);
            check_output("wm.almost_empty_low", 64'(aempty), 64'd0);
        end
        idle();
        check_output("wm.count2", 64'(count), 64'd2);
        check_output("wm.almost_empty_high", 64'(aempty), 64'd1);
        check_output("wm.almost_full_at2", 64'(afull), 64'd0);
        drain(2);
        idle();
        af_thr = 4'd8; ae_thr = 4'd0;

        // Synchronous clear with 5 stored, then a fresh word round-trips.
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 32'h51 + 32'(i), 1'b0, 1'b0);
        idle();
        check_status("preclear", 5, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h56, 1'b1, 1'b1);
        check_output("clear.push_ready", 64'(push_ready), 64'd1);
        idle();
        check_status("clear", 0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 32'h57, 1'b0, 1'b0);
        idle();
        check_status("postclear", 1, 1'b0, 1'b0);
        drain(1);
        idle();
        check_status("postclear_drain", 0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a push.
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 32'h61 + 32'(i), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        push_valid = 1'b1; push_data = 32'h66; push_strb = 4'h6; pop_ready = 1'b0;
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        check_status("midreset", 0, 1'b1, 1'b0);
        @(posedge clk);
        #1 push_valid = 1'b0;
        #2 rst_n = 1'b1;
        apply_stimulus(1'b1, 32'h67, 1'b0, 1'b0);
        idle();
        check_status("postreset", 1, 1'b0, 1'b0);
        drain(1);
        idle();
        check_status("postreset_drain", 0, 1'b1, 1'b0);

        // Fall-through instance: empty word passes in the same cycle.
        @(posedge clk);
        #1;
        ft_push_valid = 1'b1; ft_push_data = 32'hA5; ft_push_strb = 4'h5; ft_pop_ready = 1'b1;
        @(negedge clk);
        check_output("ft.pop_valid", 64'(ft_pop_valid), 64'd1);
        check_output("ft.pop_data", 64'(ft_pop_data), 64'hA5);
        check_output("ft.pop_strb", 64'(ft_pop_strb), 64'h5);
        @(posedge clk);
        #1 ft_push_valid = 1'b0; ft_pop_ready = 1'b0;
        @(negedge clk);
        check_output("ft.count_bypass", 64'(ft_count), 64'd0);
        check_output("ft.pop_valid_idle", 64'(ft_pop_valid), 64'd0);
        // Downstream stalled: the word is stored and presented next cycle.
        @(posedge clk);
        #1 ft_push_valid = 1'b1; ft_push_data = 32'h5A; ft_push_strb = 4'hA;
        @(posedge clk);
        #1 ft_push_valid = 1'b0;
        @(negedge clk);
        check_output("ft.count_stored", 64'(ft_count), 64'd1);
        check_output("ft.stored_valid", 64'(ft_pop_valid), 64'd1);
        check_output("ft.stored_data", 64'(ft_pop_data), 64'h5A);
        @(posedge clk);
        #1 ft_pop_ready = 1'b1;
        @(posedge clk);
        #1 ft_pop_ready = 1'b0;
        @(negedge clk);
        check_output("ft.count_drained", 64'(ft_count), 64'd0);

        idle();
        check_output("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
